// File: rtl/mem_stage.sv
// mem_stage: memory-access pipeline stage.
// Merges internal data-memory and external-bus load data, owns the MEM/WB
// register, and runs the external-read request/acknowledge FSM with timeout.
// The upstream pipeline stalls while an external load is outstanding.
module mem_stage #(
  parameter int unsigned TIMEOUT_CYCLES = 16,
  parameter logic [31:0] TIMEOUT_DATA   = 32'hDEADBEEF,
  parameter int unsigned CNT_W          = 5
) (
  input  logic        clk,
  input  logic        nReset,
  input  logic        flush,
  input  logic        ReadAccess,
  input  logic [7:0]  address,
  input  logic        RegWrite_Mem,
  input  logic        MemtoReg_Mem,
  input  logic        MemRead_Mem,
  input  logic [4:0]  Waddr_Mem,
  input  logic [31:0] Wdata_Mem,
  input  logic [1:0]  mhartID_Mem,
  input  logic [31:0] currentPC_Mem,
  input  logic [31:0] dmem_rdata,
  input  logic        ext_ack,
  input  logic [31:0] ext_rdata,
  output logic        ext_req,
  output logic [7:0]  ext_addr,
  output logic        stall,
  output logic        bus_err,
  output logic        RegWrite_WB,
  output logic [4:0]  Waddr_WB,
  output logic [31:0] Wdata_WB,
  output logic [1:0]  mhartID_WB,
  output logic [31:0] currentPC_WB
);

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_WAIT,
    ST_DONE
  } state_t;

  state_t           r_state;
  logic             r_ext_pend;
  logic [7:0]       r_ext_addr;
  logic             r_ext_req;
  logic             r_bus_err;
  logic [CNT_W-1:0] r_cnt;
  logic [31:0]      r_cap;

  logic             r_regwrite_wb;
  logic [4:0]       r_waddr_wb;
  logic [31:0]      r_wdata_wb;
  logic [1:0]       r_hart_wb;
  logic [31:0]      r_pc_wb;

  logic             w_stall;
  logic [31:0]      w_wb_data;
  logic             w_unused;

  // MemRead is carried through the interface only; the writeback select follows MemtoReg.
  assign w_unused = MemRead_Mem;

  // Stall while a latched external request has not yet been handed to WB.
  always_comb begin
    w_stall = (r_state == ST_WAIT) || ((r_state == ST_IDLE) && r_ext_pend);
  end

  // Writeback data select: ALU result, internal memory, or captured external data.
  always_comb begin
    w_wb_data = Wdata_Mem;
    if (MemtoReg_Mem) begin
      w_wb_data = r_ext_pend ? r_cap : dmem_rdata;
    end
  end

  // Latch the EX-stage external-read request; frozen together with the pipeline.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      r_ext_pend <= 1'b0;
      r_ext_addr <= '0;
    end else if (!w_stall) begin
      r_ext_pend <= ReadAccess & ~flush;
      r_ext_addr <= address;
    end
  end

  // External-read FSM: request, wait for ack or timeout, then release to WB.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      r_state   <= ST_IDLE;
      r_ext_req <= 1'b0;
      r_bus_err <= 1'b0;
      r_cnt     <= '0;
      r_cap     <= '0;
    end else begin
      r_bus_err <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (r_ext_pend) begin
            r_state   <= ST_WAIT;
            r_ext_req <= 1'b1;
            r_cnt     <= '0;
          end
        end
        ST_WAIT: begin
          if (ext_ack) begin
            r_cap     <= ext_rdata;
            r_ext_req <= 1'b0;
            r_state   <= ST_DONE;
          end else if (r_cnt == CNT_W'(TIMEOUT_CYCLES - 1)) begin
            r_cap     <= TIMEOUT_DATA;
            r_ext_req <= 1'b0;
            r_bus_err <= 1'b1;
            r_state   <= ST_DONE;
          end else begin
            r_cnt <= r_cnt + CNT_W'(1);
          end
        end
        ST_DONE: begin
          r_state <= ST_IDLE;
        end
        default: begin
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  // MEM/WB pipeline register; a stall inserts a bubble and holds the payload.
  always_ff @(posedge clk or negedge nReset) begin
    if (!nReset) begin
      r_regwrite_wb <= 1'b0;
      r_waddr_wb    <= '0;
      r_wdata_wb    <= '0;
      r_hart_wb     <= '0;
      r_pc_wb       <= '0;
    end else if (w_stall) begin
      r_regwrite_wb <= 1'b0;
    end else begin
      r_regwrite_wb <= RegWrite_Mem;
      r_waddr_wb    <= Waddr_Mem;
      r_wdata_wb    <= w_wb_data;
      r_hart_wb     <= mhartID_Mem;
      r_pc_wb       <= currentPC_Mem;
    end
  end

  assign ext_req      = r_ext_req;
  assign ext_addr     = r_ext_addr;
  assign stall        = w_stall;
  assign bus_err      = r_bus_err;
  assign RegWrite_WB  = r_regwrite_wb;
  assign Waddr_WB     = r_waddr_wb;
  assign Wdata_WB     = r_wdata_wb;
  assign mhartID_WB   = r_hart_wb;
  assign currentPC_WB = r_pc_wb;

endmodule

// File: doc/mem_stage.md
Name: mem_stage

Overview:
- Memory-access stage directly downstream of the execute stage. Consumes the EX/MEM pipeline register contents and the external-read request that the execute stage decodes combinationally (ReadAccess/address).
- Merges internal data-memory load data and external-bus load data, and owns the MEM/WB pipeline register.
- Runs a request/acknowledge FSM with timeout for external reads, and stalls the upstream pipeline while an external load is outstanding.

Parameters:
TIMEOUT_CYCLES, 16, max WAIT-state cycles before an external read is abandoned (must be >=2)
TIMEOUT_DATA, 32'hDEADBEEF, load value written back on timeout
CNT_W, 5, width of the wait counter (2^CNT_W > TIMEOUT_CYCLES)

Ports:
clk  input  1  system clock, all state on rising edge
nReset  input  1  asynchronous active-low reset
flush  input  1  branch/jump flush; the instruction currently in EX is being killed
ReadAccess  input  1  from EX: the load in EX targets the external bus (combinational)
address  input  8  from EX: external word address (combinational)
RegWrite_Mem, MemtoReg_Mem, MemRead_Mem  input  1 each  EX/MEM control bits
Waddr_Mem  input  5  destination register
Wdata_Mem  input  32  ALU result / store address
mhartID_Mem  input  2  hart of the instruction in MEM
currentPC_Mem  input  32  PC of the instruction in MEM
dmem_rdata  input  32  internal data-memory read data, valid in the MEM cycle
ext_ack  input  1  external bus read acknowledge, single-cycle pulse
ext_rdata  input  32  external read data, valid when ext_ack=1
ext_req  output  1  external read request, registered
ext_addr  output  8  external word address, registered, stable while ext_req=1
stall  output  1  freeze PC, IF/ID, ID/EX and EX/MEM registers
bus_err  output  1  one-cycle pulse on timeout
RegWrite_WB  output  1  MEM/WB control bit
Waddr_WB  output  5  MEM/WB destination register
Wdata_WB  output  32  MEM/WB writeback data
mhartID_WB  output  2  MEM/WB hart ID
currentPC_WB  output  32  MEM/WB PC

Behaviour:
- Reset (async, nReset=0): all outputs 0; state=IDLE; ext_pend=0; wait counter=0; captured data=0. Reset asserted mid-WAIT abandons the access immediately, with no bus_err.
- Request capture, each rising edge with stall=0: ext_pend <= ReadAccess & ~flush; ext_addr <= address. While stall=1, ext_pend and ext_addr hold.
- FSM states are IDLE, WAIT and DONE:
  - IDLE & ext_pend=1: stall=1 (combinational); next WAIT; ext_req<=1; counter<=0.
  - IDLE & ext_pend=0: stall=0.
  - WAIT: stall=1.
    - ext_ack=1 -> capture ext_rdata; ext_req<=0; next DONE.
    - Else if counter==TIMEOUT_CYCLES-1 -> capture TIMEOUT_DATA; ext_req<=0; bus_err<=1 for one cycle; next DONE.
    - Else counter increments.
  - DONE: stall=0; MEM/WB samples the captured data; ext_pend<=0 unless a new ReadAccess arrives; next IDLE.
- External-load MEM occupancy is 3 cycles minimum (ack in the first WAIT cycle) and TIMEOUT_CYCLES+2 cycles maximum.
- ext_ack outside WAIT is ignored.
- Internal loads never stall.
- MEM/WB register, stall=0:
  - RegWrite_WB<=RegWrite_Mem; Waddr_WB<=Waddr_Mem; mhartID_WB<=mhartID_Mem; currentPC_WB<=currentPC_Mem.
  - Wdata_WB<=MemtoReg_Mem ? (ext_pend ? captured : dmem_rdata) : Wdata_Mem.
- MEM/WB register, stall=1: bubble; RegWrite_WB<=0; other fields hold.
- flush does not affect the instruction already in MEM, and does not abort WAIT. flush only prevents the EX instruction's ReadAccess from being latched.
- flush and ReadAccess in the same edge: no request is generated.
- No request queue: at most one external read is outstanding.

Test Plan:
1. Reset: nReset=0 during WAIT with ext_req=1 -> ext_req=0, stall=0, all WB outputs 0 immediately, state IDLE after release.
2. Internal load: MemtoReg_Mem=1, ReadAccess=0, dmem_rdata=32'h1234_5678, Waddr_Mem=5 -> next edge Wdata_WB=32'h12345678, Waddr_WB=5, RegWrite_WB=1, stall never asserted.
3. External load with ack after 2 WAIT cycles: ReadAccess=1, address=8'h2A -> ext_addr=8'h2A, stall high 4 cycles, RegWrite_WB=0 during stall, then Wdata_WB=ext_rdata (32'hCAFE0001), mhartID_WB matches.
4. Timeout: ext_ack never asserted -> after 16 WAIT cycles bus_err pulses once, Wdata_WB=32'hDEADBEEF, stall released next cycle.
5. Flush with ReadAccess=1 on the same edge -> ext_req stays 0, no stall. A later flush during WAIT -> access completes normally.
6. Back-to-back external loads on different harts (mhartID 1, then 2) -> two separate req/ack sequences, WB hart IDs 1 then 2, data not swapped. A spurious ext_ack in IDLE is ignored.
